// File: rtl/led_wave_decoder_if.sv
// LED frame input and wave-decoder result signals, bundled for led_wave_decoder.
// master drives the LED frame and observes results; slave is the decoder side.
interface led_wave_decoder_if;
  logic [5:0] LED;
  logic [1:0] dir;
  logic       done;
  logic       err;
  logic       busy;
  logic [7:0] wave_count;

  modport master (output LED, input dir, done, err, busy, wave_count);
  modport slave  (input LED, output dir, done, err, busy, wave_count);
endinterface

// File: rtl/led_wave_decoder.sv
// Decodes right/left/up/down LED wave animations from frame changes on bus.LED.
// Define LED_WAVE_DECODER_TIMEOUT_EN to abort a sequence after TIMEOUT cycles without a change.
//
// state | meaning
// IDLE  | no sequence in progress, waiting for a start frame
// RIGHT | tracking 100000 .. 000001, 000000
// LEFT  | tracking 000001 .. 100000, 000000
// UP    | tracking 001100, 010010, 100001, 000000
// DOWN  | tracking 100001, 010010, 001100
module led_wave_decoder #(
  parameter int unsigned TIMEOUT = 32
) (
  input logic              clk,
  input logic              rst,
  led_wave_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RIGHT, LEFT, UP, DOWN} state_t;

  state_t     state, state_n, start_state;
  logic [2:0] step, step_n, last_step;
  logic [5:0] prev, expected;
  logic [1:0] dir_q, dir_n, code;
  logic       done_q, done_n, err_q, err_n;
  logic [7:0] count_q, count_n;
  logic       change, start_hit;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("led_wave_decoder: TIMEOUT must be within 2..255");
  end

`ifdef LED_WAVE_DECODER_TIMEOUT_EN
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt;
`endif

  assign change = (bus.LED != prev);

  always_comb begin
    start_hit   = 1'b1;
    start_state = IDLE;
    case (bus.LED)
      6'b100000: start_state = RIGHT;
      6'b000001: start_state = LEFT;
      6'b001100: start_state = UP;
      6'b100001: start_state = DOWN;
      default:   start_hit   = 1'b0;
    endcase
  end

  // Frame expected at the current step; the final step holds the terminal frame.
  always_comb begin
    expected  = '0;
    last_step = '0;
    code      = '0;
    case (state)
      RIGHT: begin
        code      = 2'b00;
        last_step = 3'd6;
        expected  = 6'b100000 >> step;
      end
      LEFT: begin
        code      = 2'b01;
        last_step = 3'd6;
        expected  = 6'b000001 << step;
      end
      UP: begin
        code      = 2'b10;
        last_step = 3'd3;
        case (step)
          3'd1:    expected = 6'b010010;
          3'd2:    expected = 6'b100001;
          3'd3:    expected = 6'b000000;
          default: expected = 6'b001100;
        endcase
      end
      DOWN: begin
        code      = 2'b11;
        last_step = 3'd2;
        case (step)
          3'd1:    expected = 6'b010010;
          3'd2:    expected = 6'b001100;
          default: expected = 6'b100001;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    dir_n   = dir_q;
    count_n = count_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (change) begin
      if (state != IDLE && bus.LED == expected) begin
        if (step == last_step) begin
          state_n = IDLE;
          step_n  = 3'd0;
          done_n  = 1'b1;
          dir_n   = code;
          if (count_q != 8'hFF) count_n = count_q + 8'd1;
        end else begin
          step_n = step + 3'd1;
        end
      end else begin
        // An aborting frame may itself start a new sequence on the same edge.
        err_n   = (state != IDLE);
        state_n = start_hit ? start_state : IDLE;
        step_n  = start_hit ? 3'd1 : 3'd0;
      end
    end
`ifdef LED_WAVE_DECODER_TIMEOUT_EN
    else if (state != IDLE && tcnt == TCNT_LAST) begin
      err_n   = 1'b1;
      state_n = IDLE;
      step_n  = 3'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      prev    <= '0;
      dir_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      prev    <= bus.LED;
      dir_q   <= dir_n;
      done_q  <= done_n;
      err_q   <= err_n;
      count_q <= count_n;
    end
  end

`ifdef LED_WAVE_DECODER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || change || state == IDLE) tcnt <= '0;
    else                                tcnt <= tcnt + 8'd1;
  end
`endif

  assign bus.dir        = dir_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state != IDLE);
  assign bus.wave_count = count_q;

endmodule

// File: tb/tb_led_wave_decoder.sv
// Scoreboard bench for led_wave_decoder: stimulus queues expected done/err events,
// a negedge monitor pops and compares them whenever the decoder pulses.
module tb_led_wave_decoder;

  logic clk = 1'b0;
  logic rst;

  led_wave_decoder_if bus();

  led_wave_decoder #(.TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [1:0] dir;
    logic [7:0] count;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [1:0] d, input logic [7:0] c);
    ev_t e;
    e.is_err = is_err;
    e.dir    = d;
    e.count  = c;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [5:0] f, input int n);
    bus.LED = f;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  initial begin
    forever begin
      ev_t e;
      @(negedge clk);
      if (!rst && (bus.done || bus.err)) begin
        check("done_err_exclusive", 8'(bus.done & bus.err), 8'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got done=%0b err=%0b, expected no pulse", bus.done, bus.err);
        end else begin
          e = exp_q.pop_front();
          check("event_is_err", 8'(bus.err), 8'(e.is_err));
          check("event_dir", 8'(bus.dir), 8'(e.dir));
          check("event_count", bus.wave_count, e.count);
        end
      end
    end
  end

  initial begin
    bus.LED = 6'b000000;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dir", 8'(bus.dir), 8'd0);
    check("reset_done", 8'(bus.done), 8'd0);
    check("reset_err", 8'(bus.err), 8'd0);
    check("reset_busy", 8'(bus.busy), 8'd0);
    check("reset_count", bus.wave_count, 8'd0);
    rst = 1'b0;
    drive(6'b000000, 2);

    // RIGHT, one cycle per frame
    drive(6'b100000, 1);
    check("right_busy", 8'(bus.busy), 8'd1);
    drive(6'b010000, 1);
    drive(6'b001000, 1);
    drive(6'b000100, 1);
    drive(6'b000010, 1);
    drive(6'b000001, 1);
    expect_ev(1'b0, 2'b00, 8'd1);
    drive(6'b000000, 1);
    drain("right_pending");
    check("right_idle", 8'(bus.busy), 8'd0);
    check("right_count", bus.wave_count, 8'd1);

    // UP then DOWN, two cycles per frame; held 001100 must not restart UP
    drive(6'b001100, 2);
    drive(6'b010010, 2);
    drive(6'b100001, 2);
    expect_ev(1'b0, 2'b10, 8'd2);
    drive(6'b000000, 2);
    drive(6'b100001, 2);
    drive(6'b010010, 2);
    expect_ev(1'b0, 2'b11, 8'd3);
    drive(6'b001100, 6);
    drain("updown_pending");
    check("down_no_up_start", 8'(bus.busy), 8'd0);
    check("updown_count", bus.wave_count, 8'd3);
    check("updown_dir", 8'(bus.dir), 8'd3);

    // LEFT aborted by 001100, which starts UP
    drive(6'b000001, 1);
    drive(6'b000010, 1);
    expect_ev(1'b1, 2'b11, 8'd3);
    drive(6'b001100, 1);
    check("abort_into_up_busy", 8'(bus.busy), 8'd1);
    drive(6'b010010, 1);
    drive(6'b100001, 1);
    expect_ev(1'b0, 2'b10, 8'd4);
    drive(6'b000000, 1);
    drain("abort_pending");
    check("abort_count", bus.wave_count, 8'd4);
    check("abort_dir", 8'(bus.dir), 8'd2);

    // Reset in the middle of RIGHT
    drive(6'b100000, 1);
    drive(6'b010000, 1);
    drive(6'b001000, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(6'b000100, 4);
    drain("midreset_pending");
    check("midreset_busy", 8'(bus.busy), 8'd0);
    check("midreset_count", bus.wave_count, 8'd0);
    check("midreset_dir", 8'(bus.dir), 8'd0);

    // Timeout: start RIGHT and hold the first frame
    drive(6'b000000, 2);
`ifdef LED_WAVE_DECODER_TIMEOUT_EN
    expect_ev(1'b1, 2'b00, 8'd0);
`endif
    drive(6'b100000, 40);
    drain("timeout_pending");
`ifdef LED_WAVE_DECODER_TIMEOUT_EN
    check("timeout_busy", 8'(bus.busy), 8'd0);
`else
    check("no_timeout_busy", 8'(bus.busy), 8'd1);
`endif
    check("timeout_count", bus.wave_count, 8'd0);

    bus.LED = 6'b000000;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(6'b000000, 1);

    // 256 back-to-back LEFT waves; count saturates at 255
    for (int i = 0; i < 256; i++) begin
      drive(6'b000001, 1);
      drive(6'b000010, 1);
      drive(6'b000100, 1);
      drive(6'b001000, 1);
      drive(6'b010000, 1);
      drive(6'b100000, 1);
      expect_ev(1'b0, 2'b01, (i >= 254) ? 8'd255 : 8'(i + 1));
      drive(6'b000000, 1);
    end
    drain("sat_pending");
    check("sat_count", bus.wave_count, 8'd255);
    check("sat_dir", 8'(bus.dir), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
